// File: rtl/delay_line_ctrl_if.sv
// -----------------------------------------------------------------------------
// delay_line_ctrl_if
// Groups the fetch-side inputs and the delay-line / consumer outputs of
// delay_line_ctrl into one bundle.
//   i_instr        fetched instruction word
//   i_instr_valid  i_instr is valid this cycle
//   i_stall        downstream stall, insert a NOP bubble instead of i_instr
//   i_redirect     control-flow redirect, flush the line
//   o_en           delay line parallel-load enable
//   o_data_en      delay line parallel-load word (always NOP)
//   o_data         delay line serial input word
//   o_accept       i_instr consumed this cycle
//   o_valid        word at the delay line output is valid
//   o_busy         flush or refill in progress
//   o_flush_cnt    saturating count of redirect cycles
// master: the side driving fetch inputs; slave: the controller.
// -----------------------------------------------------------------------------
interface delay_line_ctrl_if #(
    parameter int N = 32
);
    logic [N-1:0] i_instr;
    logic         i_instr_valid;
    logic         i_stall;
    logic         i_redirect;
    logic         o_en;
    logic [N-1:0] o_data_en;
    logic [N-1:0] o_data;
    logic         o_accept;
    logic         o_valid;
    logic         o_busy;
    logic [15:0]  o_flush_cnt;

    modport master (
        output i_instr, i_instr_valid, i_stall, i_redirect,
        input  o_en, o_data_en, o_data, o_accept, o_valid, o_busy, o_flush_cnt
    );

    modport slave (
        input  i_instr, i_instr_valid, i_stall, i_redirect,
        output o_en, o_data_en, o_data, o_accept, o_valid, o_busy, o_flush_cnt
    );
endinterface

// File: rtl/delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// delay_line_ctrl
// Sequencing controller for an M-stage, N-bit instruction delay line. Each
// cycle it chooses what is shifted into the line (a fetched instruction or a
// NOP bubble), pulses the line's parallel-load enable to wipe every stage to
// NOP after reset and on redirect, tracks a valid bit per stage so the
// consumer knows whether the line output is real, and counts redirect cycles.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    delay_line_ctrl_if.slave (fetch inputs, delay line/consumer outputs)
// -----------------------------------------------------------------------------
module delay_line_ctrl #(
    parameter int           M         = 3,
    parameter int           N         = 32,
    parameter logic [N-1:0] NOP       = N'(32'h00000013),
    parameter int           FLUSH_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    delay_line_ctrl_if.slave bus
);

    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam int RW = $clog2(M + 1);

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_REFILL,
        ST_RUN
    } state_t;

    state_t         r_state;
    logic [FW-1:0]  r_flush_left;   // flush cycles remaining, including the current one
    logic [RW-1:0]  r_refill_cnt;
    logic [M-1:0]   r_vsr;          // per-stage valid bits, bit M-1 lines up with the line output
    logic [15:0]    r_flush_cnt;

    logic           w_en;
    logic           w_take;

    // Redirect forces the load enable in the very cycle it is seen, so the
    // line is wiped at the same edge the controller restarts its window.
    assign w_en   = bus.i_redirect | (r_state == ST_FLUSH);
    assign w_take = bus.i_instr_valid & ~bus.i_stall & ~w_en;

    assign bus.o_en        = w_en;
    assign bus.o_data_en   = NOP;
    assign bus.o_data      = w_take ? bus.i_instr : NOP;
    assign bus.o_accept    = w_take;
    assign bus.o_valid     = r_vsr[M-1];
    assign bus.o_busy      = (r_state != ST_RUN) | w_en;
    assign bus.o_flush_cnt = r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FLUSH;
            r_flush_left <= FW'(FLUSH_CYC);
            r_refill_cnt <= '0;
            r_vsr        <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (bus.i_redirect && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end

            if (bus.i_redirect) begin
                // The redirect cycle is the first of the flush window; any
                // window already running is restarted rather than extended.
                r_vsr <= '0;
                if (FLUSH_CYC == 1) begin
                    r_state      <= ST_REFILL;
                    r_refill_cnt <= '0;
                end else begin
                    r_state      <= ST_FLUSH;
                    r_flush_left <= FW'(FLUSH_CYC - 1);
                end
            end else begin
                case (r_state)
                    ST_FLUSH: begin
                        r_vsr <= '0;
                        if (r_flush_left <= FW'(1)) begin
                            r_state      <= ST_REFILL;
                            r_refill_cnt <= '0;
                        end else begin
                            r_flush_left <= r_flush_left - FW'(1);
                        end
                    end
                    ST_REFILL: begin
                        r_vsr <= {r_vsr[M-2:0], w_take};
                        if (r_refill_cnt == RW'(M - 1)) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_refill_cnt <= r_refill_cnt + RW'(1);
                        end
                    end
                    ST_RUN: begin
                        r_vsr <= {r_vsr[M-2:0], w_take};
                    end
                    default: begin
                        r_state      <= ST_FLUSH;
                        r_flush_left <= FW'(FLUSH_CYC);
                        r_vsr        <= '0;
                    end
                endcase
            end
        end
    end

endmodule
